// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions,
// condition functions and the branch/cmov condition helper.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] ALUADD = 4'h0;
  localparam logic [3:0] ALUSUB = 4'h1;
  localparam logic [3:0] ALUAND = 4'h2;
  localparam logic [3:0] ALUXOR = 4'h3;

  localparam logic [3:0] CYES = 4'h0;
  localparam logic [3:0] CLE  = 4'h1;
  localparam logic [3:0] CL   = 4'h2;
  localparam logic [3:0] CE   = 4'h3;
  localparam logic [3:0] CNE  = 4'h4;
  localparam logic [3:0] CGE  = 4'h5;
  localparam logic [3:0] CG   = 4'h6;

  function automatic logic cond_eval(
    input logic [3:0] fn,
    input logic       z,
    input logic       s,
    input logic       o
  );
    logic r;
    r = 1'b0;
    case (fn)
      CYES:    r = 1'b1;
      CLE:     r = (s ^ o) | z;
      CL:      r = s ^ o;
      CE:      r = z;
      CNE:     r = ~z;
      CGE:     r = ~(s ^ o);
      CG:      r = ~(s ^ o) & ~z;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu64.sv
// 64-bit add/sub/and/xor with zero/sign/overflow generation.
// Overflow is produced only when EXECUTE_OF_FLAG_EN is defined.
module alu64
  import y86_pkg::*;
(
  input  logic [3:0]  fun,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] res,
  output logic        zf,
  output logic        sf,
  output logic        of
);

  logic ovf;

  always_comb begin
    res = b + a;
    ovf = 1'b0;
    unique case (1'b1)
      (fun == ALUSUB): begin
        res = b - a;
        ovf = (a[63] != b[63]) && (res[63] != b[63]);
      end
      (fun == ALUAND): res = b & a;
      (fun == ALUXOR): res = b ^ a;
      default: begin
        res = b + a;
        ovf = (a[63] == b[63]) && (res[63] != a[63]);
      end
    endcase
  end

  assign zf = (res == 64'd0);
  assign sf = res[63];

`ifdef EXECUTE_OF_FLAG_EN
  assign of = ovf;
`else
  assign of = 1'b0;
  logic unused_ovf;
  assign unused_ovf = ovf;
`endif

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand select, CC register, halt FSM.
// Overflow flag build option: EXECUTE_OF_FLAG_EN.
module execute_stage
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  input  logic [63:0] valC,
  output logic        out_valid,
  output logic [63:0] valE,
  output logic        cnd,
  output logic        zf,
  output logic        sf,
  output logic        of,
  output logic        halted,
  output logic        err
);

  typedef enum logic {RUN, HALTED} state_t;
  state_t state;

  logic [63:0] alua, alub, res;
  logic [3:0]  fun;
  logic        nzf, nsf, nof;
  logic        bad, stop, take, accept;

  always_comb begin
    alua = 64'd0;
    unique case (1'b1)
      (icode == IRRMOVQ),
      (icode == IOPQ):    alua = valA;
      (icode == IIRMOVQ),
      (icode == IRMMOVQ),
      (icode == IMRMOVQ): alua = valC;
      (icode == ICALL),
      (icode == IPUSHQ):  alua = -64'sd8;
      (icode == IRET),
      (icode == IPOPQ):   alua = 64'd8;
      default:            alua = 64'd0;
    endcase
  end

  assign alub = (icode == IRRMOVQ || icode == IIRMOVQ)
              ? 64'd0 : valB;
  assign fun  = (icode == IOPQ) ? ifun : ALUADD;

  alu64 u_alu (
    .fun (fun),
    .a   (alua),
    .b   (alub),
    .res (res),
    .zf  (nzf),
    .sf  (nsf),
    .of  (nof)
  );

  assign bad    = (icode >= 4'hC)
               || (icode == IOPQ && ifun > ALUXOR);
  assign stop   = bad || (icode == IHALT);
  assign take   = (icode == IRRMOVQ) || (icode == IJXX);
  assign accept = in_valid && (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      out_valid <= 1'b0;
      valE      <= 64'd0;
      cnd       <= 1'b0;
      zf        <= 1'b1;
      sf        <= 1'b0;
      of        <= 1'b0;
      halted    <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept && stop) begin
        valE   <= 64'd0;
        cnd    <= 1'b0;
        state  <= HALTED;
        halted <= 1'b1;
        if (bad) err <= 1'b1;
      end else if (accept) begin
        valE <= res;
        // condition sees the CC as it was before this instruction
        cnd  <= take && cond_eval(ifun, zf, sf, of);
        if (icode == IOPQ) begin
          zf <= nzf;
          sf <= nsf;
          of <= nof;
        end
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage.
// Expected overflow follows EXECUTE_OF_FLAG_EN.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  icode = 4'h1;
  logic [3:0]  ifun = 4'h0;
  logic [63:0] valA = '0;
  logic [63:0] valB = '0;
  logic [63:0] valC = '0;
  logic        out_valid, cnd, zf, sf, of, halted, err;
  logic [63:0] valE;

  int checks = 0;
  int failures = 0;

`ifdef EXECUTE_OF_FLAG_EN
  localparam logic OFX = 1'b1;
`else
  localparam logic OFX = 1'b0;
`endif

  always #5 clk = ~clk;

  execute_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .icode     (icode),
    .ifun      (ifun),
    .valA      (valA),
    .valB      (valB),
    .valC      (valC),
    .out_valid (out_valid),
    .valE      (valE),
    .cnd       (cnd),
    .zf        (zf),
    .sf        (sf),
    .of        (of),
    .halted    (halted),
    .err       (err)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(
    input logic        r,
    input logic        v,
    input logic [3:0]  ic,
    input logic [3:0]  fn,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [63:0] c
  );
    rst = r; in_valid = v; icode = ic; ifun = fn;
    valA = a; valB = b; valC = c;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 4'h1, 4'h0, '0, '0, '0);
  endtask

  task automatic chk_reset(input string t);
    check({t, "_ov"}, 64'(out_valid), 64'd0);
    check({t, "_valE"}, valE, 64'd0);
    check({t, "_cnd"}, 64'(cnd), 64'd0);
    check({t, "_zf"}, 64'(zf), 64'd1);
    check({t, "_sf"}, 64'(sf), 64'd0);
    check({t, "_of"}, 64'(of), 64'd0);
    check({t, "_halt"}, 64'(halted), 64'd0);
    check({t, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    cyc(1'b1, 1'b0, 4'h1, 4'h0, '0, '0, '0);
    chk_reset("rst0");

    cyc(0, 1, 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0);
    check("add_ov", 64'(out_valid), 64'd1);
    check("add_valE", valE, 64'h8000_0000_0000_0000);
    check("add_sf", 64'(sf), 64'd1);
    check("add_zf", 64'(zf), 64'd0);
    check("add_of", 64'(of), 64'(OFX));

    idle();
    check("idle_ov", 64'(out_valid), 64'd0);
    check("idle_hold", valE, 64'h8000_0000_0000_0000);

    cyc(0, 1, 4'h6, 4'h1, 64'd5, 64'd5, 0);
    check("sub_valE", valE, 64'd0);
    check("sub_zf", 64'(zf), 64'd1);
    check("sub_of", 64'(of), 64'd0);
    cyc(0, 1, 4'h7, 4'h3, 0, 0, 64'h40);
    check("je_ov", 64'(out_valid), 64'd1);
    check("je_cnd", 64'(cnd), 64'd1);

    cyc(0, 1, 4'h2, 4'h4, 64'h1234, 64'h9999, 0);
    check("cmovne_valE", valE, 64'h1234);
    check("cmovne_cnd", 64'(cnd), 64'd0);

    cyc(0, 1, 4'hA, 4'h0, 0, 64'h100, 0);
    check("push_valE", valE, 64'hF8);
    cyc(0, 1, 4'hB, 4'h0, 0, 64'h100, 0);
    check("pop_valE", valE, 64'h108);
    check("pop_cnd", 64'(cnd), 64'd0);
    check("pop_zf", 64'(zf), 64'd1);

    cyc(0, 1, 4'h3, 4'h0, 64'h77, 64'h88, 64'h55);
    check("irmov_valE", valE, 64'h55);

    cyc(0, 1, 4'h6, 4'h3, 64'hF0, 64'hFF, 0);
    check("xor_valE", valE, 64'h0F);
    check("xor_zf", 64'(zf), 64'd0);
    check("xor_sf", 64'(sf), 64'd0);
    cyc(0, 1, 4'h6, 4'h2, 64'hF0F0, 64'hFF00, 0);
    check("and_valE", valE, 64'hF000);
    cyc(0, 1, 4'h7, 4'h2, 0, 0, 0);
    check("jl_cnd", 64'(cnd), 64'd0);
    cyc(0, 1, 4'h7, 4'h6, 0, 0, 0);
    check("jg_cnd", 64'(cnd), 64'd1);
    cyc(0, 1, 4'h7, 4'h9, 0, 0, 0);
    check("j9_cnd", 64'(cnd), 64'd0);

    cyc(0, 1, 4'hD, 4'h0, 64'd3, 64'd4, 64'd5);
    check("bad_ov", 64'(out_valid), 64'd1);
    check("bad_valE", valE, 64'd0);
    check("bad_halt", 64'(halted), 64'd1);
    check("bad_err", 64'(err), 64'd1);
    check("bad_zf", 64'(zf), 64'd0);
    cyc(0, 1, 4'h6, 4'h1, 64'd1, 64'd1, 0);
    check("hlt_ov", 64'(out_valid), 64'd0);
    check("hlt_zf", 64'(zf), 64'd0);
    check("hlt_sticky", 64'(halted), 64'd1);

    cyc(1'b1, 1'b0, 4'h1, 4'h0, '0, '0, '0);
    chk_reset("rst1");

    cyc(0, 1, 4'h6, 4'h0, 64'd1, 64'd1, 0);
    check("pre_zf", 64'(zf), 64'd0);
    cyc(1, 1, 4'h6, 4'h0, 64'd2, 64'd2, 0);
    check("rstin_ov", 64'(out_valid), 64'd0);
    check("rstin_zf", 64'(zf), 64'd1);
    check("rstin_valE", valE, 64'd0);
    idle();
    check("rstin_after", 64'(out_valid), 64'd0);

    cyc(0, 1, 4'h6, 4'h0, 64'd2, 64'd3, 0);
    check("disc_ov1", 64'(out_valid), 64'd1);
    cyc(1'b1, 1'b0, 4'h1, 4'h0, '0, '0, '0);
    check("disc_ov2", 64'(out_valid), 64'd0);

    cyc(0, 1, 4'h0, 4'h0, 0, 0, 0);
    check("halt_ov", 64'(out_valid), 64'd1);
    check("halt_h", 64'(halted), 64'd1);
    check("halt_err", 64'(err), 64'd0);

    cyc(1'b1, 1'b0, 4'h1, 4'h0, '0, '0, '0);
    cyc(0, 1, 4'h6, 4'h4, 64'd1, 64'd1, 0);
    check("opbad_h", 64'(halted), 64'd1);
    check("opbad_err", 64'(err), 64'd1);
    check("opbad_zf", 64'(zf), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have ports: rst  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-003 SHALL have ports: in_valid  input  1  instruction fields and operands valid this cycle.
REQ-004 SHALL have ports: icode, ifun  input  4 each  instruction code and function from fetch.
REQ-005 SHALL have ports: valA, valB  input  64 each  register operands from decode; valC  input  64  constant from fetch.
REQ-006 SHALL have ports: out_valid  output  1  valE/cnd valid, one pulse per accepted instruction.
REQ-007 SHALL have ports: valE  output  64  ALU result; cnd  output  1  condition result.
REQ-008 SHALL have ports: zf, sf, of  output  1 each  current condition-code register.
REQ-009 SHALL have ports: halted  output  1  sticky halt; err  output  1  sticky invalid-instruction flag.

Function
REQ-010 SHALL accept an instruction on a clk edge where in_valid=1, rst=0 and state=RUN; latency 1 cycle: out_valid=1 with valE and cnd on the following cycle.
REQ-011 SHALL deassert out_valid on every cycle with no accepted instruction; valE and cnd hold their last values.
REQ-012 SHALL select aluA: valA for icode 2 and 6; valC for 3, 4, 5; -8 for 8 and A; +8 for 9 and B; 0 otherwise.
REQ-013 SHALL select aluB: 0 for icode 2 and 3; valB otherwise.
REQ-014 SHALL compute valE: aluB+aluA, or for icode 6: ifun 0 add, 1 sub (aluB-aluA), 2 and, 3 xor; all arithmetic 64-bit, modulo 2^64.
REQ-015 SHALL update zf/sf/of only when accepting icode 6 with ifun 0-3: zf=(res==0), sf=res[63]; of per add/sub signed overflow; of=0 for and/xor.
REQ-016 SHALL evaluate cnd from CC values before the current instruction's update, for icode 2 and 7 only: ifun 0 always, 1 le (sf^of)|zf, 2 l sf^of, 3 e zf, 4 ne ~zf, 5 ge ~(sf^of), 6 g ~(sf^of)&~zf, ifun 7-F 0.
REQ-017 SHALL drive cnd=0 for all icodes other than 2 and 7.
REQ-018 SHALL implement states RUN and HALTED; RUN->HALTED on acceptance of icode 0, icode C-F, or icode 6 with ifun 4-F.
REQ-019 SHALL, on the halting instruction: output out_valid=1 with valE=0 and cnd=0; leave CC unchanged; set halted=1; set err=1 unless icode=0.
REQ-020 SHALL ignore in_valid in HALTED: no out_valid, no CC change; exit only by reset.

Reset
REQ-021 SHALL on rst=1 set state=RUN, out_valid=0, valE=0, cnd=0, zf=1, sf=0, of=0, halted=0, err=0; rst overrides a same-cycle in_valid.
REQ-022 SHALL discard an instruction accepted in the cycle before rst; its out_valid pulse shall not appear after reset.

Configuration
REQ-023 SHALL support macro EXECUTE_OF_FLAG_EN: when defined, of is computed per REQ-015.
REQ-024 SHALL, when EXECUTE_OF_FLAG_EN is undefined, hold of constant 0; all conditions of REQ-016 then use of=0.

Structure
REQ-025 SHALL take icode values (IHALT..IPOPQ), ALU ifun codes and condition ifun codes from shared package y86_pkg.
REQ-026 SHALL place operand add/sub/and/xor and flag generation in combinational sub-module alu64; CC register, state machine and output register stay in execute_stage.

Verification
REQ-027 SHALL cover: reset, then OPq add with valA=1, valB=0x7FFFFFFFFFFFFFFF -> next cycle valE=0x8000000000000000, out_valid=1; afterwards sf=1, of=1 (of=0 without the macro), zf=0.
REQ-028 SHALL cover: OPq sub with valA=5, valB=5, followed next cycle by jXX ifun 3 -> valE=0, zf=1; the jXX gives cnd=1.
REQ-029 SHALL cover: with zf=1 set, a back-to-back cmov ifun 4 carrying valA=0x1234 -> valE=0x1234, cnd=0.
REQ-030 SHALL cover: pushq with valB=0x100 -> valE=0xF8; popq with valB=0x100 -> valE=0x108; CC unchanged.
REQ-031 SHALL cover: icode 0xD accepted -> halted=1, err=1; further in_valid produces no out_valid; rst -> all outputs per REQ-021.
REQ-032 SHALL cover: rst asserted together with in_valid carrying OPq -> out_valid=0 next cycle and zf=1.
